// File: rtl/mem_arb_pkg.sv
// Shared encodings for the core/loader memory arbiter.
// Grant values match the state encoding, so the state register drives grant directly.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_C = 2'b01,
        BUSY_L = 2'b10
    } state_e;

    localparam logic [1:0] GRANT_NONE   = 2'b00;
    localparam logic [1:0] GRANT_CORE   = 2'b01;
    localparam logic [1:0] GRANT_LOADER = 2'b10;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: req[0] is the core, req[1] the loader.
// On a tie the requester that was not granted last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,   // 1 = loader was granted last
    output logic [1:0] pick
);

    always_comb begin
        // NOTE: assign a default before the case so every path drives pick and no latch is inferred.
        pick = GRANT_NONE;
        case (req)
            2'b01:   pick = GRANT_CORE;
            2'b10:   pick = GRANT_LOADER;
            2'b11:   pick = last ? GRANT_CORE : GRANT_LOADER;
            default: pick = GRANT_NONE;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between a core and a loader/DMA engine,
// with round-robin on ties and bounded back-to-back loader bursts under l_lock.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int AW        = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [31:0]   c_wdata,
    output logic          c_ready,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [31:0]   l_wdata,
    input  logic          l_lock,
    output logic          l_ready,
    output logic [31:0]   rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    output logic [1:0]    grant
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    state_e        state_q, state_d;
    logic          mem_en_q, mem_en_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          last_q, last_d;
    logic [1:0]    pick;
    logic          burst_more;

    rr_pick2 u_pick (
        .req  ({l_req, c_req}),
        .last (last_q),
        .pick (pick)
    );

    // The counter saturates at MAX_BURST-1: the ack that would reach MAX_BURST leaves BUSY_L instead.
    assign burst_more = l_lock && l_req && (int'(burst_q) < MAX_BURST - 1);

    always_comb begin
        state_d  = state_q;
        mem_en_d = mem_en_q;
        burst_d  = burst_q;
        last_d   = last_q;
        case (state_q)
            IDLE: begin
                if (pick == GRANT_CORE) begin
                    state_d  = BUSY_C;
                    mem_en_d = 1'b1;
                    last_d   = 1'b0;
                end else if (pick == GRANT_LOADER) begin
                    state_d  = BUSY_L;
                    mem_en_d = 1'b1;
                    last_d   = 1'b1;
                end
            end
            BUSY_C: begin
                if (mem_ack) begin
                    state_d  = IDLE;
                    mem_en_d = 1'b0;
                end
            end
            BUSY_L: begin
                if (mem_ack) begin
                    if (burst_more) begin
                        burst_d = burst_q + BW'(1);
                    end else begin
                        state_d  = IDLE;
                        mem_en_d = 1'b0;
                        burst_d  = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                burst_d  = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mem_en_q <= 1'b0;
            burst_q  <= '0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            mem_en_q <= mem_en_d;
            burst_q  <= burst_d;
            last_q   <= last_d;
        end
    end

    // The owner's command is steered straight through; owners hold it stable until ready.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            BUSY_C: begin
                mem_we    = c_we;
                mem_addr  = c_addr;
                mem_wdata = c_wdata;
            end
            BUSY_L: begin
                mem_we    = l_we;
                mem_addr  = l_addr;
                mem_wdata = l_wdata;
            end
            default: ;
        endcase
    end

    assign mem_en  = mem_en_q;
    assign grant   = state_q;
    assign c_ready = (state_q == BUSY_C) && mem_ack;
    assign l_ready = (state_q == BUSY_L) && mem_ack;
    assign rdata   = (c_ready || l_ready) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level owner model checked every cycle,
// plus hand-computed expectations for latency, tie order, burst limit, wait states and reset.
module tb_mem_arbiter;

    localparam int MAX_BURST = 8;
    localparam int AW        = 32;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } op_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          c_req = 1'b0, c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [31:0]   c_wdata = '0;
    logic          c_ready;
    logic          l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
    logic [AW-1:0] l_addr = '0;
    logic [31:0]   l_wdata = '0;
    logic          l_ready;
    logic [31:0]   rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic [1:0]    grant;

    mem_arbiter #(.MAX_BURST(MAX_BURST), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ready(c_ready),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
        .l_ready(l_ready), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant(grant)
    );

    always #5 clk = ~clk;

    // Owner model: 0 none, 1 core, 2 loader; served counts loader acks in the current grant.
    int owner = 0, last_won = 2, served = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            owner    <= 0;
            last_won <= 2;
            served   <= 0;
        end else if (owner == 0) begin
            if (c_req && (!l_req || last_won == 2)) begin
                owner    <= 1;
                last_won <= 1;
            end else if (l_req) begin
                owner    <= 2;
                last_won <= 2;
            end
        end else if (mem_ack) begin
            if (owner == 2 && l_lock && l_req && served + 1 < MAX_BURST) begin
                served <= served + 1;
            end else begin
                owner  <= 0;
                served <= 0;
            end
        end
    end

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requester queues, memory responder and logs, all owned by the single driver process.
    op_t        c_q[$], l_q[$];
    int         cyc = 0, lat = 1, acc_cnt = 0;
    logic       lock_mode = 1'b0, stray_ack = 1'b0;
    logic [31:0] rd_val = 32'h0;
    logic       prev_en = 1'b0, prev_ack = 1'b0, c_seen = 1'b0, l_seen = 1'b0;
    logic       m_prev_creq = 1'b0, m_prev_en = 1'b0, m_prev_ack = 1'b0;
    logic [AW-1:0] m_prev_addr = '0;
    logic [31:0] m_prev_wdata = '0;

    int         c_rise, en_first, c_rdy_cyc, n_c, n_l, n_ev, en_cycles, unstable;
    logic [31:0] c_rdata;
    logic [63:0] rlog;
    logic [1:0] glog[$];

    function automatic op_t mk(input logic we, input logic [AW-1:0] a, input logic [31:0] d);
        op_t o;
        o.we = we; o.addr = a; o.wdata = d;
        return o;
    endfunction

    task automatic clear_logs();
        c_rise = -1; en_first = -1; c_rdy_cyc = -1;
        n_c = 0; n_l = 0; n_ev = 0; en_cycles = 0; unstable = 0;
        c_rdata = '0; rlog = '0;
        glog.delete();
    endtask

    task automatic compare_and_log();
        check("grant", {62'd0, grant}, (owner == 1) ? 64'd1 : (owner == 2) ? 64'd2 : 64'd0);
        check("mem_en", {63'd0, mem_en}, {63'd0, owner != 0});
        if (owner == 1) begin
            check("mem_we_c", {63'd0, mem_we}, {63'd0, c_we});
            check("mem_addr_c", {32'd0, mem_addr}, {32'd0, c_addr});
            check("mem_wdata_c", {32'd0, mem_wdata}, {32'd0, c_wdata});
        end else if (owner == 2) begin
            check("mem_we_l", {63'd0, mem_we}, {63'd0, l_we});
            check("mem_addr_l", {32'd0, mem_addr}, {32'd0, l_addr});
            check("mem_wdata_l", {32'd0, mem_wdata}, {32'd0, l_wdata});
        end
        check("c_ready", {63'd0, c_ready}, {63'd0, owner == 1 && mem_ack});
        check("l_ready", {63'd0, l_ready}, {63'd0, owner == 2 && mem_ack});
        check("ready_exclusive", {63'd0, c_ready && l_ready}, 64'd0);
        if (c_ready || l_ready) check("rdata", {32'd0, rdata}, {32'd0, mem_rdata});

        if (c_req && !m_prev_creq && c_rise < 0) c_rise = cyc;
        if (mem_en && en_first < 0) en_first = cyc;
        if (mem_en) en_cycles++;
        if (mem_en && m_prev_en && !m_prev_ack &&
            (mem_addr != m_prev_addr || mem_wdata != m_prev_wdata)) unstable++;
        if (c_ready) begin
            n_c++; n_ev++; c_rdy_cyc = cyc; c_rdata = rdata;
            rlog = {rlog[62:0], 1'b0};
        end
        if (l_ready) begin
            n_l++; n_ev++;
            rlog = {rlog[62:0], 1'b1};
        end
        if (glog.size() == 0 || glog[$] != grant) glog.push_back(grant);

        m_prev_creq = c_req; m_prev_en = mem_en; m_prev_ack = mem_ack;
        m_prev_addr = mem_addr; m_prev_wdata = mem_wdata;
        c_seen = c_ready; l_seen = l_ready;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (c_seen && c_q.size() > 0) void'(c_q.pop_front());
        if (l_seen && l_q.size() > 0) void'(l_q.pop_front());
        c_req   = (c_q.size() > 0);
        c_we    = c_req ? c_q[0].we : 1'b0;
        c_addr  = c_req ? c_q[0].addr : '0;
        c_wdata = c_req ? c_q[0].wdata : '0;
        l_req   = (l_q.size() > 0);
        l_we    = l_req ? l_q[0].we : 1'b0;
        l_addr  = l_req ? l_q[0].addr : '0;
        l_wdata = l_req ? l_q[0].wdata : '0;
        l_lock  = lock_mode && (l_q.size() > 1);
        if (mem_en) acc_cnt = (prev_ack || !prev_en) ? 1 : acc_cnt + 1;
        else        acc_cnt = 0;
        mem_ack   = (mem_en && acc_cnt == lat + 1) || stray_ack;
        mem_rdata = rd_val;
        prev_en   = mem_en;
        prev_ack  = mem_ack;
        #1;
        compare_and_log();
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!(c_q.size() == 0 && l_q.size() == 0 && grant == 2'b00 && !mem_en) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_completed"}, {63'd0, c_q.size() == 0 && l_q.size() == 0 && grant == 2'b00}, 64'd1);
    endtask

    initial begin
        clear_logs();

        // Reset state
        tick(); tick();
        check("rst_grant", {62'd0, grant}, 64'd0);
        check("rst_mem_en", {63'd0, mem_en}, 64'd0);
        check("rst_mem_we", {63'd0, mem_we}, 64'd0);
        check("rst_readies", {62'd0, c_ready, l_ready}, 64'd0);
        @(posedge clk); #3 reset = 1'b0;

        // Tie straight after reset: core first, then loader
        clear_logs();
        c_q.push_back(mk(1'b0, 32'h100, 32'h0));
        l_q.push_back(mk(1'b1, 32'h200, 32'h1111));
        wait_done("tie", 40);
        check("tie_glog_len", glog.size(), 64'd5);
        if (glog.size() == 5) begin
            check("tie_g1", {62'd0, glog[1]}, 64'd1);
            check("tie_g2", {62'd0, glog[2]}, 64'd0);
            check("tie_g3", {62'd0, glog[3]}, 64'd2);
        end
        check("tie_order", rlog, 64'b01);
        check("tie_events", n_ev, 64'd2);

        // Core-only read, ack one cycle after mem_en
        clear_logs();
        rd_val = 32'hDEADBEEF;
        c_q.push_back(mk(1'b0, 32'h40, 32'h0));
        wait_done("core", 40);
        check("core_en_latency", en_first - c_rise, 64'd1);
        check("core_ready_latency", c_rdy_cyc - c_rise, 64'd2);
        check("core_rdata", {32'd0, c_rdata}, 64'hDEADBEEF);
        check("core_ready_count", n_c, 64'd1);
        check("core_grant_end", {62'd0, grant}, 64'd0);

        // Five wait states on a core write
        clear_logs();
        lat = 5;
        c_q.push_back(mk(1'b1, 32'h1234, 32'hCAFE0001));
        wait_done("wait", 60);
        check("wait_unstable", unstable, 64'd0);
        check("wait_en_cycles", en_cycles, 64'd6);
        check("wait_ready_count", n_c, 64'd1);
        check("wait_ack_delay", c_rdy_cyc - en_first, 64'd5);

        // Locked loader burst of 10 writes, core arriving two cycles later
        clear_logs();
        lat = 1;
        lock_mode = 1'b1;
        for (int i = 0; i < 10; i++) l_q.push_back(mk(1'b1, 32'h1000 + 32'(4 * i), 32'(i)));
        tick(); tick();
        c_q.push_back(mk(1'b0, 32'h80, 32'h0));
        wait_done("burst", 200);
        check("burst_order", rlog, 64'h7FB);
        check("burst_events", n_ev, 64'd11);
        check("burst_loader_acks", n_l, 64'd10);
        check("burst_core_acks", n_c, 64'd1);
        check("burst_unstable", unstable, 64'd0);
        lock_mode = 1'b0;

        // Reset two cycles into a core access, then a stray ack
        clear_logs();
        lat = 10;
        c_q.push_back(mk(1'b0, 32'h300, 32'h0));
        for (int i = 0; i < 10 && grant != 2'b01; i++) tick();
        check("rst_mid_granted", {62'd0, grant}, 64'd1);
        tick();
        #2 reset = 1'b1;
        c_q.delete();
        #1;
        check("rst_mid_mem_en", {63'd0, mem_en}, 64'd0);
        check("rst_mid_grant", {62'd0, grant}, 64'd0);
        check("rst_mid_c_ready", {63'd0, c_ready}, 64'd0);
        tick();
        @(posedge clk); #3 reset = 1'b0;
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        tick(); tick(); tick();
        check("stray_c_ready", n_c, 64'd0);
        check("stray_l_ready", n_l, 64'd0);
        check("stray_grant", {62'd0, grant}, 64'd0);
        check("stray_mem_en", {63'd0, mem_en}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
